// File: rtl/segdisplay_mux.sv
// N-digit multiplexed common-anode seven-segment driver with per-digit blanking,
// decimal points, PWM brightness and frame-latched (tear-free) digit snapshots.
module segdisplay_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 65536,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [BRIGHT_W-1:0]     bright,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Wide enough for (bright+1)*CLK_DIV with no loss before the shift.
  localparam int OW = BRIGHT_W + 33;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           pre_cnt_r;
  logic [IW-1:0]           idx_r;
  logic [4*NUM_DIGITS-1:0] shadow_digits_r;
  logic [NUM_DIGITS-1:0]   shadow_blank_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r;
  logic [6:0]              seg_r;
  logic [NUM_DIGITS-1:0]   an_r;
  logic                    dp_r;
  logic                    frame_start_r;

  logic                    tick_s;
  logic                    wrap_s;
  logic [OW-1:0]           on_prod_s;
  logic [OW-1:0]           on_cyc_s;
  logic                    window_s;
  logic [3:0]              cur_nib_s;
  logic                    cur_blank_s;
  logic                    cur_dp_s;
  logic                    lit_s;
  logic [NUM_DIGITS-1:0]   an_sel_s;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Slot timing, brightness window and current-digit selection.
  always_comb begin
    tick_s      = (pre_cnt_r == PRE_MAX);
    wrap_s      = tick_s && (idx_r == IDX_MAX);
    on_prod_s   = (OW'(bright) + OW'(1)) * OW'(CLK_DIV);
    on_cyc_s    = on_prod_s >> BRIGHT_W;
    // Cycle 0 of every slot stays dark so adjacent anodes never overlap.
    window_s    = (pre_cnt_r != PW'(0)) && (OW'(pre_cnt_r) < on_cyc_s);
    cur_nib_s   = 4'h0;
    cur_blank_s = 1'b1;
    cur_dp_s    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      cur_nib_s   = (idx_r == IW'(k)) ? shadow_digits_r[4*k +: 4] : cur_nib_s;
      cur_blank_s = (idx_r == IW'(k)) ? shadow_blank_r[k] : cur_blank_s;
      cur_dp_s    = (idx_r == IW'(k)) ? shadow_dp_r[k] : cur_dp_s;
    end
    lit_s       = window_s && !cur_blank_s;
    an_sel_s    = ~(NUM_DIGITS'(1) << idx_r);
  end

  // Prescaler and scan index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_r <= PW'(0);
      idx_r     <= IW'(0);
    end else begin
      if (tick_s) begin
        pre_cnt_r <= PW'(0);
        idx_r     <= (idx_r == IDX_MAX) ? IW'(0) : idx_r + IW'(1);
      end else begin
        pre_cnt_r <= pre_cnt_r + PW'(1);
        idx_r     <= idx_r;
      end
    end
  end

  // Frame snapshot of the display inputs, taken on the wrap back to digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_digits_r <= '0;
      shadow_blank_r  <= '1;
      shadow_dp_r     <= '0;
    end else if (wrap_s) begin
      shadow_digits_r <= digits_in;
      shadow_blank_r  <= blank_in;
      shadow_dp_r     <= dp_in;
    end else begin
      shadow_digits_r <= shadow_digits_r;
      shadow_blank_r  <= shadow_blank_r;
      shadow_dp_r     <= shadow_dp_r;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r         <= 7'h7F;
      an_r          <= '1;
      dp_r          <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      seg_r         <= lit_s ? hex_decode(cur_nib_s) : 7'h7F;
      an_r          <= lit_s ? an_sel_s : '1;
      dp_r          <= lit_s ? ~cur_dp_s : 1'b1;
      frame_start_r <= wrap_s;
    end
  end

  assign seg         = seg_r;
  assign an          = an_r;
  assign dp          = dp_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_segdisplay_mux.sv
// Bench for segdisplay_mux: a 4-digit and an 8-digit instance (CLK_DIV=16) checked
// every cycle against a cycle-count based display model plus directed literal checks.
module tb_segdisplay_mux;

  localparam int D  = 16;
  localparam int BW = 4;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    int          e;
    logic [31:0] dig;
    logic [7:0]  blank;
    logic [7:0]  dpm;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        fs;
  } model_t;

  logic        clk = 1'b0;
  logic        rst4, rst8;
  logic [15:0] digits4;
  logic [3:0]  blank4, dpin4, bright4;
  logic [6:0]  seg4;
  logic [3:0]  an4;
  logic        dp4, fs4;
  logic [31:0] digits8;
  logic [7:0]  blank8, dpin8;
  logic [3:0]  bright8;
  logic [6:0]  seg8;
  logic [7:0]  an8;
  logic        dp8, fs8;

  model_t m4, m8;
  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  segdisplay_mux #(.NUM_DIGITS(4), .CLK_DIV(D), .BRIGHT_W(BW)) dut4 (
    .clk(clk), .rst(rst4), .digits_in(digits4), .blank_in(blank4), .dp_in(dpin4),
    .bright(bright4), .seg(seg4), .an(an4), .dp(dp4), .frame_start(fs4));

  segdisplay_mux #(.NUM_DIGITS(8), .CLK_DIV(D), .BRIGHT_W(BW)) dut8 (
    .clk(clk), .rst(rst8), .digits_in(digits8), .blank_in(blank8), .dp_in(dpin8),
    .bright(bright8), .seg(seg8), .an(an8), .dp(dp8), .frame_start(fs8));

  function automatic model_t m_reset();
    model_t m;
    m.e = 0; m.dig = 32'h0; m.blank = 8'hFF; m.dpm = 8'h00;
    m.an = 8'hFF; m.seg = 7'h7F; m.dp = 1'b1; m.fs = 1'b0;
    return m;
  endfunction

  // Edge number e shows what counter value e (cycles since reset) selects.
  function automatic model_t m_step(model_t m, int n, logic [31:0] din, logic [7:0] bin,
                                    logic [7:0] dpin, logic [3:0] br);
    int phase = m.e % D;
    int slot  = (m.e / D) % n;
    int onc   = ((int'(br) + 1) * D) >> BW;
    m.an = 8'hFF; m.seg = 7'h7F; m.dp = 1'b1;
    if (phase != 0 && phase < onc && !m.blank[slot]) begin
      m.an[slot] = 1'b0;
      m.seg      = HEX[m.dig[slot*4 +: 4]];
      m.dp       = ~m.dpm[slot];
    end
    m.fs = ((m.e % (D * n)) == (D * n - 1));
    if (m.fs) begin
      m.dig = din; m.blank = bin; m.dpm = dpin;
    end
    m.e = m.e + 1;
    return m;
  endfunction

  always @(posedge clk or posedge rst4)
    if (rst4) m4 <= m_reset();
    else      m4 <= m_step(m4, 4, {16'h0, digits4}, {4'h0, blank4}, {4'h0, dpin4}, bright4);

  always @(posedge clk or posedge rst8)
    if (rst8) m8 <= m_reset();
    else      m8 <= m_step(m8, 8, digits8, blank8, dpin8, bright8);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the models.
  always @(negedge clk) begin
    if (!rst4) begin
      chk("an4", {28'h0, an4}, {28'h0, m4.an[3:0]});
      chk("seg4", {25'h0, seg4}, {25'h0, m4.seg});
      chk("dp4", {31'h0, dp4}, {31'h0, m4.dp});
      chk("fs4", {31'h0, fs4}, {31'h0, m4.fs});
    end
    if (!rst8) begin
      chk("an8", {24'h0, an8}, {24'h0, m8.an});
      chk("seg8", {25'h0, seg8}, {25'h0, m8.seg});
      chk("dp8", {31'h0, dp8}, {31'h0, m8.dp});
      chk("fs8", {31'h0, fs8}, {31'h0, m8.fs});
    end
  end

  task automatic wait_e4(input int target);
    int i = 0;
    while (m4.e < target && i < 1000) begin
      @(negedge clk);
      i++;
    end
    if (m4.e != target) begin
      nmis++;
      $display("FAIL wait4: reached edge %0d expected %0d", m4.e, target);
    end
  endtask

  task automatic wait_e8(input int target);
    int i = 0;
    while (m8.e < target && i < 1000) begin
      @(negedge clk);
      i++;
    end
    if (m8.e != target) begin
      nmis++;
      $display("FAIL wait8: reached edge %0d expected %0d", m8.e, target);
    end
  endtask

  task automatic count_low4(input int from, input int to, output int n);
    n = 0;
    for (int e = from; e <= to; e++) begin
      wait_e4(e);
      if (an4 != 4'hF) n++;
    end
  endtask

  task automatic wait_fs4(input string name, input int exp_e);
    int i = 0;
    int dark_bad = 0;
    while (!fs4 && i < 100) begin
      if (an4 != 4'hF) dark_bad++;
      @(negedge clk);
      i++;
    end
    chk({name, "_edge"}, m4.e, exp_e);
    chk({name, "_dark"}, dark_bad, 0);
  endtask

  task automatic seq4();
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_tab [4] = '{7'h0E, 7'h30, 7'h08, 7'h79};
    logic       dp_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int cnt [4] = '{0, 0, 0, 0};
    int n;
    wait_fs4("fs4_first", 64);
    // Second frame: literal pattern and active cycles per slot.
    for (int e = 65; e <= 128; e++) begin
      wait_e4(e);
      if (an4 != 4'hF) cnt[(e - 65) / 16]++;
      if (e <= 114 && ((e - 66) % 16) == 0) begin
        chk("scan_an", {28'h0, an4}, {28'h0, an_tab[(e - 66) / 16]});
        chk("scan_seg", {25'h0, seg4}, {25'h0, seg_tab[(e - 66) / 16]});
        chk("scan_dp", {31'h0, dp4}, {31'h0, dp_tab[(e - 66) / 16]});
      end
      if (e == 100) digits4 = 16'h1111;
    end
    for (int k = 0; k < 4; k++) chk("slot_active15", cnt[k], 15);
    // Tear-free: change inputs while digit 1 of the 1111 frame is on.
    wait_e4(150); digits4 = 16'h2222;
    wait_e4(170);
    chk("tear_an2", {28'h0, an4}, 32'h0000000B);
    chk("tear_seg2", {25'h0, seg4}, 32'h00000079);
    wait_e4(180);
    chk("tear_seg3", {25'h0, seg4}, 32'h00000079);
    wait_e4(192);
    chk("tear_fs", {31'h0, fs4}, 32'h1);
    wait_e4(196);
    chk("tear_new_an", {28'h0, an4}, 32'h0000000E);
    chk("tear_new_seg", {25'h0, seg4}, 32'h00000024);
    // Brightness.
    wait_e4(200); bright4 = 4'd7;
    count_low4(257, 272, n);
    chk("bright7_cnt", n, 7);
    bright4 = 4'd0;
    count_low4(273, 288, n);
    chk("bright0_cnt", n, 0);
    bright4 = 4'hF;
    // Blanking of digit 1.
    wait_e4(290); blank4 = 4'b0010;
    count_low4(337, 352, n);
    chk("blank1_cnt", n, 0);
    count_low4(353, 368, n);
    chk("blank_other_cnt", n, 15);
    wait_e4(370); blank4 = 4'b0000;
    // Asynchronous reset in the middle of an active slot.
    wait_e4(405);
    chk("pre_rst_an", {28'h0, an4}, 32'h0000000D);
    #2 rst4 = 1'b1;
    #1;
    chk("async_rst_an", {28'h0, an4}, 32'h0000000F);
    chk("async_rst_seg", {25'h0, seg4}, 32'h0000007F);
    chk("async_rst_dp", {31'h0, dp4}, 32'h1);
    @(negedge clk); @(negedge clk);
    rst4 = 1'b0;
    wait_fs4("fs4_after_rst", 64);
    wait_e4(66);
    chk("resume_an0", {28'h0, an4}, 32'h0000000E);
    chk("resume_seg0", {25'h0, seg4}, 32'h00000024);
    wait_e4(82);
    chk("resume_an1", {28'h0, an4}, 32'h0000000D);
  endtask

  task automatic seq8();
    logic [6:0] seg_tab [8] = '{7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    logic [7:0] an_w;
    int i = 0;
    while (!fs8 && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("fs8_first", m8.e, 128);
    for (int k = 0; k < 8; k++) begin
      wait_e8(128 + 16 * k + 2);
      an_w = 8'h01;
      an_w = ~(an_w << k);
      chk("walk8_an", {24'h0, an8}, {24'h0, an_w});
      chk("walk8_seg", {25'h0, seg8}, {25'h0, seg_tab[k]});
    end
    wait_e8(256);
    chk("fs8_period", {31'h0, fs8}, 32'h1);
  endtask

  initial begin
    rst4 = 1'b1; rst8 = 1'b1;
    digits4 = 16'h1A3F; blank4 = 4'h0; dpin4 = 4'b0100; bright4 = 4'hF;
    digits8 = 32'h01234567; blank8 = 8'h00; dpin8 = 8'h00; bright8 = 4'hF;
    repeat (3) @(negedge clk);
    rst4 = 1'b0; rst8 = 1'b0;
    #1;
    chk("rst_an", {28'h0, an4}, 32'h0000000F);
    chk("rst_seg", {25'h0, seg4}, 32'h0000007F);
    chk("rst_dp", {31'h0, dp4}, 32'h1);
    chk("rst_fs", {31'h0, fs4}, 32'h0);
    fork
      seq4();
      seq8();
    join
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/segdisplay_mux.md
Name: segdisplay_mux

Overview:
- Parametrised successor to the fixed 4-digit seven-segment controller.
- Drives an N-digit, common-anode, multiplexed seven-segment display from hex nibbles.
- Adds per-digit blanking, per-digit decimal points, PWM brightness and tear-free frame snapshots.
- Instantiated in the top level next to the VGA controller. Game logic feeds it scores/turn info; outputs go straight to the board's seg/an/dp pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (1..8).
- CLK_DIV, 65536: clk cycles per digit slot. Must be >= 2^BRIGHT_W.
- BRIGHT_W, 4: width of the brightness control.

Ports:
- clk  in  1  master clock.
- rst  in  1  asynchronous, active-high reset.
- digits_in  in  4*NUM_DIGITS  hex nibble per digit; digit k = digits_in[4k+3:4k]; digit 0 is rightmost.
- blank_in  in  NUM_DIGITS  1 = digit k dark.
- dp_in  in  NUM_DIGITS  1 = decimal point of digit k lit.
- bright  in  BRIGHT_W  brightness level; 0 = dimmest, all-ones = full.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- an  out  NUM_DIGITS  anode enables, active low.
- dp  out  1  decimal point, active low.
- frame_start  out  1  one-cycle pulse when a new scan frame begins.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous, active-high. All state is reset asynchronously.
- Reset values:
  - pre_cnt = 0, idx = 0.
  - Shadow digits = 0, shadow blank = all 1s, shadow dp = 0.
  - seg = 7'h7F, an = all 1s, dp = 1, frame_start = 0.
- Prescaler:
  - pre_cnt counts 0..CLK_DIV-1 and wraps.
  - tick = (pre_cnt == CLK_DIV-1).
- Scan index:
  - idx advances on tick, 0..NUM_DIGITS-1, then wraps to 0.
- Snapshot:
  - On tick with idx == NUM_DIGITS-1, digits_in, blank_in and dp_in are latched into shadow registers on the same edge that sets idx to 0.
  - Display uses shadows only. Input changes mid-frame never appear until the next frame.
- frame_start:
  - Registered; high exactly on the cycle idx becomes 0 via wrap.
  - Never asserted by reset itself.
- Brightness window:
  - on_cyc = ((bright+1) * CLK_DIV) >> BRIGHT_W, computed at full width with no truncation before the shift.
  - Slot active when 1 <= pre_cnt < on_cyc.
  - pre_cnt == 0 is always dark (anti-ghost guard).
  - bright is sampled live; no snapshot.
- Output stage (all outputs registered, 1-cycle latency from pre_cnt/idx):
  - Active slot, digit idx not blanked:
    - an = ~(1 << idx).
    - seg = hex decode of shadow nibble idx.
    - dp = ~shadow_dp[idx].
  - Otherwise: an = all 1s, seg = 7'h7F, dp = 1.
- Hex decode (hex values of active-low {g..a}):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- At most one an bit is low at any time, including across slot boundaries.
- Reset mid-frame: outputs go dark immediately (asynchronous). Scan restarts at idx 0 with all digits blank until the first wrap loads the shadows.

Test Plan:
- Reset/startup (CLK_DIV=16, NUM_DIGITS=4):
  - Hold rst, then release -> an=4'hF, seg=7F, dp=1.
  - First 64 cycles all dark (shadows blank).
  - frame_start pulses at cycle 64 after release.
- Static scan: digits_in=16'h1A3F, blank_in=0, dp_in=4'b0100, bright=F.
  - Second frame shows, in order: an=1110 seg=0E; an=1101 seg=30; an=1011 seg=08 dp=0; an=0111 seg=79.
  - Each slot has 15 active cycles and 1 dark cycle.
- Tear-free: change digits_in from 16'h1111 to 16'h2222 while idx=1.
  - Digits 2 and 3 of that frame still show 79.
  - 24 appears only after the next frame_start.
- Brightness: bright=0, CLK_DIV=16, BRIGHT_W=4 -> on_cyc=1, so slots are fully dark.
  - bright=7 -> 7 active cycles per slot (pre_cnt 1..7).
  - Check an low-count per slot.
- Blanking/reset mid-frame:
  - blank_in=4'b0010 -> slot 1 fully dark while the other slots scan normally.
  - Assert rst asynchronously mid-slot -> an=all 1s within the same cycle.
  - After release, scan resumes at idx=0.
- Parameter sweep: NUM_DIGITS=8, digits_in=32'h01234567.
  - 8-slot frame; an walks 11111110..01111111.
  - frame_start period = 8*CLK_DIV.
